// File: rtl/lcd_refresh_controller.sv
// HD44780 16x2 LCD sequencer: power-up wait, init commands, then endless refresh of 32 cells.
// Defining LCD_FRAME_CLEAR_EN adds a 0x01 clear command at the start of every frame.
//   state       | meaning
//   PWRUP       | wait PWRUP_CYCLES after reset
//   INIT        | load first init command
//   LINE_ADDR   | load 0x80/0xC0 line address (or per-frame clear)
//   FETCH       | sample and translate char_in for char_index
//   XFER_SETUP  | data/rs valid, enable low
//   XFER_EN     | enable high for EN_CYCLES
//   XFER_WAIT   | enable low for CMD_WAIT (CLR_WAIT after 0x01)
module lcd_refresh_controller #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int EN_CYCLES    = 16,
  parameter int CMD_WAIT     = 2500,
  parameter int CLR_WAIT     = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] char_index,
  input  logic [7:0] char_in,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_A   = (PWRUP_CYCLES > CLR_WAIT) ? PWRUP_CYCLES : CLR_WAIT;
  localparam int MAX_B   = (EN_CYCLES > CMD_WAIT) ? EN_CYCLES : CMD_WAIT;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_LINE_ADDR, S_FETCH, S_XFER_SETUP, S_XFER_EN, S_XFER_WAIT
  } state_t;

  typedef enum logic [1:0] {K_INIT, K_ADDR, K_DATA, K_CLR} kind_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_step;
  kind_t            r_kind;
  logic [4:0]       r_idx;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_en;
  logic             r_on;
  logic             r_init_done;
  logic             r_frame_done;

  state_t           w_state_nxt;
  kind_t            w_kind_nxt;
  logic [1:0]       w_step_nxt;
  logic [4:0]       w_idx_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_rs_nxt;
  logic             w_init_done_set;
  logic             w_frame_pulse;
  logic [CNT_W-1:0] w_limit;
  logic             w_cnt_done;
  logic             w_long_wait;

  function automatic logic [7:0] f_init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] f_hex(input logic [7:0] v);
    if (v < 8'h0A)      return v + 8'h30;
    else if (v < 8'h10) return v + 8'h37;
    else                return v;
  endfunction

  assign w_long_wait = !r_rs && (r_data == 8'h01);

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_PWRUP:     w_limit = CNT_W'(PWRUP_CYCLES - 1);
      S_XFER_EN:   w_limit = CNT_W'(EN_CYCLES - 1);
      S_XFER_WAIT: w_limit = w_long_wait ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
      default:     w_limit = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_limit);

  // State register plus the transfer datapath that rides along with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_PWRUP;
      r_cnt        <= '0;
      r_step       <= 2'd0;
      r_kind       <= K_INIT;
      r_idx        <= 5'd0;
      r_data       <= 8'h00;
      r_rs         <= 1'b0;
      r_en         <= 1'b0;
      r_on         <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_step       <= w_step_nxt;
      r_kind       <= w_kind_nxt;
      r_idx        <= w_idx_nxt;
      r_data       <= w_data_nxt;
      r_rs         <= w_rs_nxt;
      r_en         <= (w_state_nxt == S_XFER_EN);
      r_on         <= 1'b1;
      r_init_done  <= r_init_done | w_init_done_set;
      r_frame_done <= w_frame_pulse;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_kind_nxt      = r_kind;
    w_step_nxt      = r_step;
    w_idx_nxt       = r_idx;
    w_data_nxt      = r_data;
    w_rs_nxt        = r_rs;
    w_init_done_set = 1'b0;
    w_frame_pulse   = 1'b0;
    case (r_state)
      S_PWRUP: if (w_cnt_done) w_state_nxt = S_INIT;
      S_INIT: begin
        w_data_nxt  = f_init_cmd(r_step);
        w_rs_nxt    = 1'b0;
        w_kind_nxt  = K_INIT;
        w_state_nxt = S_XFER_SETUP;
      end
      S_LINE_ADDR: begin
        w_rs_nxt    = 1'b0;
        w_state_nxt = S_XFER_SETUP;
`ifdef LCD_FRAME_CLEAR_EN
        if (r_idx == 5'd0 && r_kind != K_CLR) begin
          w_data_nxt = 8'h01;
          w_kind_nxt = K_CLR;
        end else begin
          w_data_nxt = r_idx[4] ? 8'hC0 : 8'h80;
          w_kind_nxt = K_ADDR;
        end
`else
        w_data_nxt = r_idx[4] ? 8'hC0 : 8'h80;
        w_kind_nxt = K_ADDR;
`endif
      end
      S_FETCH: begin
        w_data_nxt  = f_hex(char_in);
        w_rs_nxt    = 1'b1;
        w_kind_nxt  = K_DATA;
        w_state_nxt = S_XFER_SETUP;
      end
      S_XFER_SETUP: w_state_nxt = S_XFER_EN;
      S_XFER_EN:    if (w_cnt_done) w_state_nxt = S_XFER_WAIT;
      S_XFER_WAIT: begin
        if (w_cnt_done) begin
          case (r_kind)
            K_INIT: begin
              if (r_step == 2'd3) begin
                w_init_done_set = 1'b1;
                w_state_nxt     = S_LINE_ADDR;
              end else begin
                // Chain init commands back-to-back so the gap is only the wait
                w_step_nxt  = r_step + 2'd1;
                w_data_nxt  = f_init_cmd(r_step + 2'd1);
                w_rs_nxt    = 1'b0;
                w_state_nxt = S_XFER_SETUP;
              end
            end
            K_ADDR: w_state_nxt = S_FETCH;
            K_CLR:  w_state_nxt = S_LINE_ADDR;
            default: begin
              w_idx_nxt = r_idx + 5'd1;
              if (r_idx == 5'h1F) begin
                w_frame_pulse = 1'b1;
                w_state_nxt   = S_LINE_ADDR;
              end else if (r_idx == 5'h0F) begin
                w_state_nxt = S_LINE_ADDR;
              end else begin
                w_state_nxt = S_FETCH;
              end
            end
          endcase
        end
      end
      default: w_state_nxt = S_PWRUP;
    endcase
  end

  always_comb begin
    char_index = r_idx;
    lcd_data   = r_data;
    lcd_rs     = r_rs;
    lcd_rw     = 1'b0;
    lcd_en     = r_en;
    lcd_on     = r_on;
    init_done  = r_init_done;
    frame_done = r_frame_done;
  end

endmodule

// File: tb/tb_lcd_refresh_controller.sv
// Directed bench for lcd_refresh_controller with short timing parameters.
// Build with +define+LCD_FRAME_CLEAR_EN to check the per-frame clear variant.
module tb_lcd_refresh_controller;

`ifdef LCD_FRAME_CLEAR_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] char_index;
  logic [7:0] char_in;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic       init_done;
  logic       frame_done;
  logic       hex_mode;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_refresh_controller #(
    .PWRUP_CYCLES(10),
    .EN_CYCLES   (2),
    .CMD_WAIT    (3),
    .CLR_WAIT    (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_index(char_index),
    .char_in   (char_in),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_on    (lcd_on),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  assign char_in = hex_mode ? {3'b000, char_index} : 8'h49;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Panel-side monitor: captured {rs,data} per enable pulse, enable low/high widths, frame stats
  logic [8:0] q_byte[$];
  int         q_lo[$];
  int         q_hi[$];
  logic       q_idone[$];
  int         q_dcnt[$];
  int         q_d49[$];
  int         q_fdw[$];
  int         unstable = 0;

  initial begin
    logic       prev_en;
    logic       prev_fd;
    logic [8:0] cur;
    int         lo;
    int         hi;
    int         fdw;
    int         dcnt;
    int         d49;
    prev_en = 0; prev_fd = 0; cur = '0; lo = 0; hi = 0; fdw = 0; dcnt = 0; d49 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_byte.delete(); q_lo.delete(); q_hi.delete(); q_idone.delete();
        q_dcnt.delete(); q_d49.delete(); q_fdw.delete();
        prev_en = 0; prev_fd = 0; lo = 0; hi = 0; fdw = 0; dcnt = 0; d49 = 0;
      end else begin
        if (lcd_en) begin
          if (!prev_en) begin
            cur = {lcd_rs, lcd_data};
            q_byte.push_back(cur);
            q_lo.push_back(lo);
            q_idone.push_back(init_done);
            hi = 1;
            if (lcd_rs) begin
              dcnt++;
              if (lcd_data == 8'h49) d49++;
            end
          end else begin
            hi++;
            if ({lcd_rs, lcd_data} != cur) unstable++;
          end
        end else begin
          if (prev_en) begin
            q_hi.push_back(hi);
            lo = 1;
          end else begin
            lo++;
          end
        end
        if (frame_done) begin
          if (!prev_fd) begin
            q_dcnt.push_back(dcnt);
            q_d49.push_back(d49);
            dcnt = 0; d49 = 0; fdw = 1;
          end else begin
            fdw++;
          end
        end else if (prev_fd) begin
          q_fdw.push_back(fdw);
        end
        prev_en = lcd_en;
        prev_fd = frame_done;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (q_byte.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_bytes", 32'(q_byte.size() >= n), 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (q_dcnt.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_frames", 32'(q_dcnt.size() >= n), 32'd1);
  endtask

  initial begin
    int k;
    int base;
    rst_n    = 1'b1;
    hex_mode = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_data",  32'(lcd_data),   32'h00);
    check("rst_rs",    32'(lcd_rs),     32'd0);
    check("rst_rw",    32'(lcd_rw),     32'd0);
    check("rst_en",    32'(lcd_en),     32'd0);
    check("rst_on",    32'(lcd_on),     32'd0);
    check("rst_idone", 32'(init_done),  32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_idx",   32'(char_index), 32'd0);

    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("on_after_release", 32'(lcd_on), 32'd1);
    check("en_after_release", 32'(lcd_en), 32'd0);

    // Init sequence and first frame in hex mode (char_in = index)
    wait_bytes(39 + 2*OFF, 2000);
    check("pwrup_en_low", 32'(q_lo[0] >= 10), 32'd1);
    check("init0", 32'(q_byte[0]), 32'h038);
    check("init0_en_w", 32'(q_hi[0]), 32'd2);
    check("init1", 32'(q_byte[1]), 32'h00C);
    check("init2", 32'(q_byte[2]), 32'h001);
    check("init3", 32'(q_byte[3]), 32'h006);
    check("gap_after_38", 32'(q_lo[1]), 32'd4);
    check("gap_after_0c", 32'(q_lo[2]), 32'd4);
    check("gap_after_01", 32'(q_lo[3]), 32'd6);
    check("idone_before", 32'(q_idone[3]), 32'd0);
    check("idone_after",  32'(q_idone[4]), 32'd1);
`ifdef LCD_FRAME_CLEAR_EN
    check("frame0_clear", 32'(q_byte[4]), 32'h001);
    check("frame1_clear", 32'(q_byte[38 + OFF]), 32'h001);
`endif
    check("frame0_addr", 32'(q_byte[4 + OFF]), 32'h080);
    base = 5 + OFF;
    check("hex_00", 32'(q_byte[base]),      32'h130);
    check("hex_09", 32'(q_byte[base + 9]),  32'h139);
    check("hex_0a", 32'(q_byte[base + 10]), 32'h141);
    check("hex_0f", 32'(q_byte[base + 15]), 32'h146);
    check("line2_addr", 32'(q_byte[base + 16]), 32'h0C0);
    check("pass_10", 32'(q_byte[base + 17]), 32'h110);
    check("pass_1f", 32'(q_byte[base + 32]), 32'h11F);
    check("frame1_addr", 32'(q_byte[38 + 2*OFF]), 32'h080);

    // Constant 0x49 lookup, switched before frame 1 fetches its first cell
    hex_mode = 1'b0;
    wait_frames(3, 3000);
    check("f0_data_cnt", 32'(q_dcnt[0]), 32'd32);
    check("f0_49_cnt",   32'(q_d49[0]),  32'd0);
    check("f1_data_cnt", 32'(q_dcnt[1]), 32'd32);
    check("f1_49_cnt",   32'(q_d49[1]),  32'd32);
    check("f2_data_cnt", 32'(q_dcnt[2]), 32'd32);
    check("f2_49_cnt",   32'(q_d49[2]),  32'd32);
    check("fdone_w0", 32'(q_fdw[0]), 32'd1);
    check("fdone_w1", 32'(q_fdw[1]), 32'd1);
    check("frame2_addr",  32'(q_byte[72 + 3*OFF]), 32'h080);
    check("frame2_cell0", 32'(q_byte[73 + 3*OFF]), 32'h149);

    // Reset in the middle of a data write
    k = 0;
    while (!(lcd_en && lcd_rs) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("found_data_en", 32'(lcd_en && lcd_rs), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_en",    32'(lcd_en),     32'd0);
    check("abort_on",    32'(lcd_on),     32'd0);
    check("abort_idx",   32'(char_index), 32'd0);
    check("abort_idone", 32'(init_done),  32'd0);
    hex_mode = 1'b1;
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    wait_bytes(6 + OFF, 2000);
    check("re_pwrup_low", 32'(q_lo[0] >= 10), 32'd1);
    check("re_init0", 32'(q_byte[0]), 32'h038);
    check("re_init3", 32'(q_byte[3]), 32'h006);
    check("re_gap_01", 32'(q_lo[3]), 32'd6);
    check("re_addr", 32'(q_byte[4 + OFF]), 32'h080);
    check("re_cell0", 32'(q_byte[5 + OFF]), 32'h130);

    check("data_stable_during_en", 32'(unstable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
